tachometer_pulse_gen: RTL and testbench

Tachometer emulator: converts a commanded RPM into a tachometer pulse train at PULSES_PER_REV pulses per revolution.
- It is the transmit side of the tachometer_interface link.
- Drives tachometer_interface in benches and in hardware-in-loop builds in place of the real motor sensor.
- Timebase is the shared clk_enable tick (10 kHz default).
- Uses a phase accumulator, no divider, so the long-run average pulse frequency is exact.

---
 rtl/tachometer_pulse_gen_if.sv | 29 ++
 rtl/tachometer_pulse_gen.sv | 129 ++++++++++++
 tb/tb_tachometer_pulse_gen.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tachometer_pulse_gen_if.sv
// Tachometer emulator signal bundle.
//   master : pulse consumer / controller side (drives enable and rpm,
//            observes the pulse train and status).
//   slave  : tachometer_pulse_gen side.
// Signals:
//   enable_in            request pulse generation
//   rpm_in               commanded speed, unsigned RPM
//   tachometer_pulse_out registered tach square wave
//   pulse_count_out      rising edges emitted since reset (wraps)
//   active_out           generator is in LOW or HIGH
interface tachometer_pulse_gen_if #(
  parameter int RPM_WIDTH = 10
);
  logic                 enable_in;
  logic [RPM_WIDTH-1:0] rpm_in;
  logic                 tachometer_pulse_out;
  logic [15:0]          pulse_count_out;
  logic                 active_out;

  modport master (
    output enable_in, rpm_in,
    input  tachometer_pulse_out, pulse_count_out, active_out
  );

  modport slave (
    input  enable_in, rpm_in,
    output tachometer_pulse_out, pulse_count_out, active_out
  );
endinterface

// File: rtl/tachometer_pulse_gen.sv
// Tachometer emulator: turns a commanded RPM into a square wave at
// PULSES_PER_REV pulses per revolution, timed by the shared clk_en tick.
// A phase accumulator adds rpm*PULSES_PER_REV every tick and toggles the
// output each time it crosses HALF = TICK_HZ*30, so the long-run average
// frequency is exact without any divider.
// Ports:
//   clk_in    system clock
//   reset_in  asynchronous active-low reset
//   clk_en    single-cycle timebase tick; state only moves on ticks
//   tach_if   slave side of tachometer_pulse_gen_if (enable/rpm in,
//             pulse/count/active out, all outputs registered)
module tachometer_pulse_gen #(
  parameter int PULSES_PER_REV = 20,
  parameter int TICK_HZ        = 10000,
  parameter int RPM_WIDTH      = 10,
  // Must hold HALF + largest step without overflow.
  parameter int ACC_WIDTH      = 20
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   clk_en,
  tachometer_pulse_gen_if.slave  tach_if
);

  localparam logic [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(TICK_HZ * 30);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
  logic [ACC_WIDTH-1:0]   step_q,  step_d;
  logic                   tach_q,  tach_d;
  logic [15:0]            cnt_q,   cnt_d;
  logic                   active_q, active_d;

  logic [RPM_WIDTH-1:0]   rpm_s;
  logic [ACC_WIDTH-1:0]   rpm_step;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   run_req;

  assign rpm_s    = tach_if.rpm_in;
  assign rpm_step = ACC_WIDTH'(rpm_s) * ACC_WIDTH'(PULSES_PER_REV);
  // A zero speed is treated exactly like a dropped enable.
  assign run_req  = tach_if.enable_in && (rpm_s != '0);
  assign sum      = acc_q + step_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    step_d   = step_q;
    tach_d   = tach_q;
    cnt_d    = cnt_q;
    if (clk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          // Entry tick only latches the step; accumulation starts next tick.
          acc_d  = '0;
          tach_d = 1'b0;
          if (run_req) begin
            step_d  = rpm_step;
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (sum >= HALF) begin
            acc_d   = sum - HALF;
            state_d = ST_HIGH;
            tach_d  = 1'b1;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            acc_d = sum;
          end
        end
        ST_HIGH: begin
          if (sum >= HALF) begin
            // Falling edge: the only place inputs are re-sampled, so a
            // HIGH phase is never cut short and no runt pulse can appear.
            tach_d = 1'b0;
            if (run_req) begin
              acc_d   = sum - HALF;
              step_d  = rpm_step;
              state_d = ST_LOW;
            end else begin
              acc_d   = '0;
              step_d  = '0;
              state_d = ST_IDLE;
            end
          end else begin
            acc_d = sum;
          end
        end
        default: begin
          acc_d   = '0;
          step_d  = '0;
          tach_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      step_q   <= '0;
      tach_q   <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      tach_q   <= tach_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign tach_if.tachometer_pulse_out = tach_q;
  assign tach_if.pulse_count_out      = cnt_q;
  assign tach_if.active_out           = active_q;

endmodule

// File: tb/tb_tachometer_pulse_gen.sv
module tb_tachometer_pulse_gen;
  localparam int     PPR     = 20;
  localparam int     TICK_HZ = 10000;
  localparam int     RPM_W   = 10;
  localparam int     ACC_W   = 20;
  localparam longint HALF    = longint'(TICK_HZ) * 30;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b0;

  tachometer_pulse_gen_if #(.RPM_WIDTH(RPM_W)) tif ();

  tachometer_pulse_gen #(
    .PULSES_PER_REV(PPR),
    .TICK_HZ       (TICK_HZ),
    .RPM_WIDTH     (RPM_W),
    .ACC_WIDTH     (ACC_W)
  ) dut (
    .clk_in  (clk),
    .reset_in(rst_n),
    .clk_en  (clk_en),
    .tach_if (tif.slave)
  );

  always #4 clk = ~clk;

  // Irregular tick spacing: outputs must ignore the non-tick edges.
  always @(negedge clk) clk_en = ($urandom_range(0, 1) == 1);

  int     errors = 0;
  int     checks = 0;
  longint tick_no = 0;
  logic   prev_tach = 1'b0;
  longint rises[$];
  longint falls[$];

  // Reference: with a constant step s entered at tick k, the n-th toggle
  // happens at the first tick t with s*(t-k) >= n*HALF.
  function automatic longint nth_toggle(longint k, longint s, int n);
    return k + (longint'(n) * HALF + s - 1) / s;
  endfunction

  function automatic longint toggles_by(longint elapsed, longint s);
    return (elapsed * s) / HALF;
  endfunction

  task automatic wait_tick();
    @(posedge clk);
    while (clk_en !== 1'b1) @(posedge clk);
    #1;
    tick_no++;
    if (tif.tachometer_pulse_out && !prev_tach) rises.push_back(tick_no);
    else if (!tif.tachometer_pulse_out && prev_tach) falls.push_back(tick_no);
    prev_tach = tif.tachometer_pulse_out;
  endtask

  task automatic run_ticks(int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic clear_log();
    rises.delete();
    falls.delete();
    prev_tach = tif.tachometer_pulse_out;
  endtask

  task automatic do_reset();
    tif.enable_in = 1'b0;
    tif.rpm_in    = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clear_log();
  endtask

  // Starts generation; returns the entry tick.
  task automatic start(input int rpm, output longint k);
    tif.enable_in = 1'b1;
    tif.rpm_in    = RPM_W'(rpm);
    clear_log();
    wait_tick();
    k = tick_no;
  endtask

  task automatic test_reset();
    tif.enable_in = 1'b1;
    tif.rpm_in    = RPM_W'(300);
    rst_n = 1'b0;
    run_ticks(5);
    checks++; if (tif.tachometer_pulse_out !== 1'b0) begin errors++; $display("FAIL reset_tach: got %0b want 0", tif.tachometer_pulse_out); end
    checks++; if (tif.pulse_count_out !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", tif.pulse_count_out); end
    checks++; if (tif.active_out !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b want 0", tif.active_out); end
    do_reset();
  endtask

  task automatic test_first_pulse();
    longint k;
    bit seen = 0;
    start(300, k);
    checks++; if (tif.active_out !== 1'b1 || tif.tachometer_pulse_out !== 1'b0)
      begin errors++; $display("FAIL entry_state: active=%0b tach=%0b want 1/0", tif.active_out, tif.tachometer_pulse_out); end
    for (int i = 0; i < 400 && falls.size() < 2; i++) begin
      wait_tick();
      if (!seen && rises.size() == 1) begin
        seen = 1;
        checks++; if (tif.pulse_count_out !== 16'd1) begin errors++; $display("FAIL first_count: got %0d want 1", tif.pulse_count_out); end
      end
    end
    checks++;
    if (falls.size() < 2 || rises.size() < 2) begin errors++; $display("FAIL first_pulse_timeout: rises=%0d falls=%0d want 2/2", rises.size(), falls.size()); return; end
    checks++; if (rises[0] !== nth_toggle(k, 6000, 1)) begin errors++; $display("FAIL first_rise: got %0d want %0d", rises[0] - k, nth_toggle(k, 6000, 1) - k); end
    checks++; if (falls[0] !== k + 100) begin errors++; $display("FAIL first_fall: got %0d want 100", falls[0] - k); end
    checks++; if (rises[1] - rises[0] !== 100) begin errors++; $display("FAIL period_300: got %0d want 100", rises[1] - rises[0]); end
  endtask

  task automatic test_one_second();
    longint k;
    longint exp_cnt;
    do_reset();
    start(300, k);
    run_ticks(TICK_HZ);
    exp_cnt = (toggles_by(TICK_HZ, 300 * PPR) + 1) / 2;
    checks++; if (longint'(tif.pulse_count_out) !== exp_cnt) begin errors++; $display("FAIL one_second_count: got %0d want %0d", tif.pulse_count_out, exp_cnt); end
    checks++; if (rises.size() !== 100) begin errors++; $display("FAIL one_second_rises: got %0d want 100", rises.size()); end
  endtask

  task automatic test_max_rpm();
    longint k, s, prev, t;
    longint exp_cnt;
    int bad_hp = 0, bad_t = 0;
    do_reset();
    s = 1023 * PPR;
    start(1023, k);
    run_ticks(3000);
    prev = k;
    for (int i = 0; i < rises.size() + falls.size(); i++) begin
      t = (i % 2 == 0) ? rises[i / 2] : falls[i / 2];
      if (t !== nth_toggle(k, s, i + 1)) bad_t++;
      if (i > 0 && (t - prev) != 14 && (t - prev) != 15) bad_hp++;
      prev = t;
    end
    exp_cnt = (toggles_by(3000, s) + 1) / 2;
    checks++; if (bad_hp != 0) begin errors++; $display("FAIL max_half_period: %0d half-periods outside 14..15", bad_hp); end
    checks++; if (bad_t != 0) begin errors++; $display("FAIL max_edge_times: %0d edges off model", bad_t); end
    checks++; if (longint'(tif.pulse_count_out) !== exp_cnt || tif.pulse_count_out < 102 || tif.pulse_count_out > 103)
      begin errors++; $display("FAIL max_count: got %0d want %0d", tif.pulse_count_out, exp_cnt); end
  endtask

  task automatic test_rpm_change();
    longint k, r, f;
    do_reset();
    start(300, k);
    for (int i = 0; i < 200 && rises.size() < 1; i++) wait_tick();
    checks++; if (rises.size() < 1) begin errors++; $display("FAIL change_timeout_rise: rises=%0d want 1", rises.size()); return; end
    r = rises[0];
    run_ticks(7);
    tif.rpm_in = RPM_W'(600);
    for (int i = 0; i < 300 && falls.size() < 3; i++) wait_tick();
    checks++; if (falls.size() < 3 || rises.size() < 3) begin errors++; $display("FAIL change_timeout: rises=%0d falls=%0d want 3/3", rises.size(), falls.size()); return; end
    f = falls[0];
    checks++; if (f - r !== 50) begin errors++; $display("FAIL change_high_len: got %0d want 50", f - r); end
    checks++; if (rises[1] - f !== 25 || falls[1] - rises[1] !== 25) begin errors++; $display("FAIL change_next_pulse: low=%0d high=%0d want 25/25", rises[1] - f, falls[1] - rises[1]); end
    checks++; if (rises[2] - falls[1] !== 25 || falls[2] - rises[2] !== 25) begin errors++; $display("FAIL change_steady: low=%0d high=%0d want 25/25", rises[2] - falls[1], falls[2] - rises[2]); end
  endtask

  task automatic test_stop_enable();
    longint k, f;
    int cnt0;
    do_reset();
    start(300, k);
    for (int i = 0; i < 200 && falls.size() < 1; i++) wait_tick();
    checks++; if (falls.size() < 1) begin errors++; $display("FAIL stop_timeout_fall: falls=%0d want 1", falls.size()); return; end
    f = falls[0];
    run_ticks(5);
    tif.enable_in = 1'b0;
    cnt0 = int'(tif.pulse_count_out);
    for (int i = 0; i < 200 && falls.size() < 2; i++) wait_tick();
    checks++; if (falls.size() < 2 || rises.size() < 2) begin errors++; $display("FAIL stop_timeout: rises=%0d falls=%0d want 2/2", rises.size(), falls.size()); return; end
    checks++; if (rises[1] - f !== 50 || falls[1] - f !== 100) begin errors++; $display("FAIL stop_last_pulse: rise=%0d fall=%0d want 50/100", rises[1] - f, falls[1] - f); end
    checks++; if (tif.active_out !== 1'b0 || tif.tachometer_pulse_out !== 1'b0) begin errors++; $display("FAIL stop_idle: active=%0b tach=%0b want 0/0", tif.active_out, tif.tachometer_pulse_out); end
    run_ticks(200);
    checks++; if (rises.size() !== 2 || int'(tif.pulse_count_out) !== cnt0 + 1) begin errors++; $display("FAIL stop_no_more: rises=%0d count=%0d want 2/%0d", rises.size(), tif.pulse_count_out, cnt0 + 1); end
  endtask

  task automatic test_stop_rpm0();
    longint k, r;
    start(300, k);
    for (int i = 0; i < 200 && rises.size() < 1; i++) wait_tick();
    checks++; if (rises.size() < 1) begin errors++; $display("FAIL rpm0_timeout_rise: rises=%0d want 1", rises.size()); return; end
    r = rises[0];
    run_ticks(3);
    tif.rpm_in = '0;
    for (int i = 0; i < 200 && falls.size() < 1; i++) wait_tick();
    checks++; if (falls.size() < 1 || falls[0] - r !== 50) begin errors++; $display("FAIL rpm0_fall: falls=%0d want fall 50 ticks after rise", falls.size()); return; end
    checks++; if (tif.active_out !== 1'b0) begin errors++; $display("FAIL rpm0_idle: active=%0b want 0", tif.active_out); end
    run_ticks(150);
    checks++; if (rises.size() !== 1) begin errors++; $display("FAIL rpm0_no_more: rises=%0d want 1", rises.size()); end
    tif.enable_in = 1'b0;
  endtask

  task automatic test_hold();
    longint k;
    logic       t0, a0;
    logic [15:0] c0;
    int idle_edges = 0, bad = 0;
    do_reset();
    start(1023, k);
    run_ticks(40);
    t0 = tif.tachometer_pulse_out; c0 = tif.pulse_count_out; a0 = tif.active_out;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (clk_en) begin
        tick_no++;
        t0 = tif.tachometer_pulse_out; c0 = tif.pulse_count_out; a0 = tif.active_out;
      end else begin
        idle_edges++;
        if (tif.tachometer_pulse_out !== t0 || tif.pulse_count_out !== c0 || tif.active_out !== a0) bad++;
      end
    end
    checks++; if (bad != 0 || idle_edges == 0) begin errors++; $display("FAIL hold_no_tick: changed on %0d of %0d idle edges, want 0", bad, idle_edges); end
  endtask

  task automatic test_reset_mid_high();
    longint k;
    do_reset();
    start(300, k);
    for (int i = 0; i < 200 && rises.size() < 1; i++) wait_tick();
    checks++; if (rises.size() < 1) begin errors++; $display("FAIL midreset_timeout: rises=%0d want 1", rises.size()); return; end
    run_ticks(10);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tif.tachometer_pulse_out !== 1'b0 || tif.pulse_count_out !== 16'd0 || tif.active_out !== 1'b0)
      begin errors++; $display("FAIL midreset_async: tach=%0b count=%0d active=%0b want 0/0/0", tif.tachometer_pulse_out, tif.pulse_count_out, tif.active_out); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clear_log();
    wait_tick();
    k = tick_no;
    for (int i = 0; i < 100 && rises.size() < 1; i++) wait_tick();
    checks++; if (rises.size() < 1 || rises[0] - k !== 50) begin errors++; $display("FAIL midreset_restart: rises=%0d want first rise 50 ticks after entry", rises.size()); end
  endtask

  task automatic test_random();
    longint k, s, dur, tg;
    int rpm, bad;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      rpm = $urandom_range(150, 1023);
      dur = $urandom_range(300, 1200);
      s   = longint'(rpm) * PPR;
      start(rpm, k);
      run_ticks(int'(dur));
      tg  = toggles_by(dur, s);
      bad = 0;
      for (int i = 0; i < rises.size(); i++) if (rises[i] !== nth_toggle(k, s, 2 * i + 1)) bad++;
      checks++; if (longint'(tif.pulse_count_out) !== (tg + 1) / 2) begin errors++; $display("FAIL rand_count rpm=%0d: got %0d want %0d", rpm, tif.pulse_count_out, (tg + 1) / 2); end
      checks++; if (tif.tachometer_pulse_out !== tg[0]) begin errors++; $display("FAIL rand_level rpm=%0d: got %0b want %0b", rpm, tif.tachometer_pulse_out, tg[0]); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_edges rpm=%0d: %0d rises off model", rpm, bad); end
    end
  endtask

  initial begin
    tif.enable_in = 1'b0;
    tif.rpm_in    = '0;
    test_reset();
    test_first_pulse();
    test_one_second();
    test_max_rpm();
    test_rpm_change();
    test_stop_enable();
    test_stop_rpm0();
    test_hold();
    test_reset_mid_high();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
